i2s_stream_tx: RTL and testbench
================================

# i2s_stream_tx

Parametrised I2S transmitter that generates its own SCLK/LRCLK from the system clock, accepts stereo samples over a valid/ready stream into an internal FIFO, and serialises one stereo frame per LRCLK period. It sits between the audio sample producer (tone generator, sample playback) and the codec's I2S pins. It replaces the fixed-pattern, externally clocked transmitter with configurable sample and slot width, underrun detection and flow control.

## Interface
- DATA_W, 24, sample width per channel (bits), 1..SLOT_W
- SLOT_W, 32, SCLK periods per channel slot
- SCLK_DIV, 4, Clk cycles per SCLK half-period, ≥1
- FIFO_DEPTH, 8, stereo sample entries, power of two, ≥2
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Enable  in  1  1 = run serial clocks; 0 = serial side idle
- sample_valid  in  1  producer has sample_l/sample_r
- sample_ready  out  1  FIFO can accept; transfer when valid&ready
- sample_l  in  DATA_W  left sample, two's complement
- sample_r  in  DATA_W  right sample, two's complement
- SCLK  out  1  I2S bit clock (registered)
- LRCLK  out  1  word select, 0 = left, 1 = right (registered)
- I2S_Dout  out  1  serial data, MSB first (registered)
- underrun  out  1  one-Clk pulse when a frame starts with FIFO empty
- fifo_level  out  $clog2(FIFO_DEPTH+1)  entries held

## Operation
- Divider div_cnt counts 0..SCLK_DIV-1; at terminal count SCLK toggles. SCLK falling edge = "fall event"; all serial updates occur only on fall events.
- bit_cnt n counts 0..2*SLOT_W-1, advances on each fall event, wraps to 0.
- On fall event with new index n: LRCLK <= (n ≥ SLOT_W); I2S_Dout <= next bit of frame shift register.
- Frame = {sample_l, (SLOT_W-DATA_W) zeros, sample_r, (SLOT_W-DATA_W) zeros}, 2*SLOT_W bits, MSB first. One-bit I2S delay: left MSB driven at n=1, right MSB at n=SLOT_W+1.
- At n=0 fall event: I2S_Dout <= final bit of outgoing frame, then shift register reloads from FIFO head (pop). FIFO empty → load all-zero frame, pulse underrun.
- FIFO: sample_ready = (fifo_level < FIFO_DEPTH). Push and pop in same cycle both succeed; level unchanged. When full, ready = 0 even if a pop occurs that cycle.
- Enable = 0: div_cnt, bit_cnt, shift register cleared; SCLK, LRCLK, I2S_Dout held 0; FIFO contents kept, pushes still accepted.
- Enable 0→1: SCLK starts low; first toggle is rising; first fall event is n=0 (first pop).
- Enable dropped mid-frame: frame abandoned, popped sample discarded.
- Reset (any time): SCLK=0, LRCLK=0, I2S_Dout=0, underrun=0, fifo_level=0, sample_ready=1 after release, FIFO emptied.

## Timing
- SCLK period = 2*SCLK_DIV Clk; frame = 4*SLOT_W*SCLK_DIV Clk (512 at defaults).
- SCLK fall, LRCLK and I2S_Dout change on same Clk edge; data stable on SCLK rising edge.
- Push to earliest appearance on I2S_Dout: next n=0 pop, then n=1 MSB.
- underrun asserted exactly one Clk, coincident with n=0 fall event.
- sample_ready reflects registered level; no combinational path from sample_valid.

## Configuration
- I2S_TX_HOLD_LAST_EN defined: on underrun the shift register reloads the last successfully popped frame (zero after reset); underrun still pulses.
- Not defined: underrun loads all-zero frame (silence).

## Structure
- Package i2s_pkg: default parameter constants, bit-count width function, frame-pack function (samples → 2*SLOT_W frame).
- Sub-module sync_fifo (WIDTH=2*DATA_W, DEPTH=FIFO_DEPTH): push/pop, full/empty, level; Clk and async active-high Reset.
- Top holds divider, bit counter, shift register, underrun logic.

## Test plan
- Defaults, push L=24'hF00000, R=24'h0ABCDE, Enable=1 → at n=1..24 Dout = F00000 MSB first while LRCLK=0; n=33..56 = 0ABCDE with LRCLK=1; remaining bits 0.
- Enable with empty FIFO → underrun pulses once per 512 Clk; Dout constantly 0 (with I2S_TX_HOLD_LAST_EN: repeats last pushed frame).
- Hold sample_valid=1 with Enable=0 → 8 pushes accepted, sample_ready falls, fifo_level=8; push and pop same cycle at level 3 → level stays 3.
- SCLK_DIV=1, SLOT_W=DATA_W=16 → SCLK period 2 Clk, frame 64 Clk; right LSB appears at n=0 of next frame.
- Assert Reset mid-frame at n=20 → all outputs 0 same cycle, fifo_level=0; after release, restart yields first fall event as n=0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared defaults, counter-width helper and frame packing for the I2S stream transmitter.
package i2s_pkg;

    localparam int unsigned DEF_DATA_W     = 24;
    localparam int unsigned DEF_SLOT_W     = 32;
    localparam int unsigned DEF_SCLK_DIV   = 4;
    localparam int unsigned DEF_FIFO_DEPTH = 8;

    // Widest slot the packing helper supports; frames are built at this width then truncated.
    localparam int unsigned MAX_SLOT_W     = 64;

    typedef logic [MAX_SLOT_W-1:0]   slot_t;
    typedef logic [2*MAX_SLOT_W-1:0] frame_t;

    // Bits needed to hold a counter running 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 32'(1) : 32'($clog2(n));
    endfunction

    // Left sample MSB-aligned in the upper slot, right sample MSB-aligned in the lower slot.
    function automatic frame_t pack_frame(input slot_t       l,
                                          input slot_t       r,
                                          input int unsigned data_w,
                                          input int unsigned slot_w);
        return (frame_t'(l) << (2*slot_w - data_w)) | (frame_t'(r) << (slot_w - data_w));
    endfunction

endpackage

// File: rtl/i2s_stream_tx_fifo.sv
// sync_fifo: stereo sample buffer with registered level, ready and empty flags.
module sync_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = 2*DEF_DATA_W,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rd_data_c_o,
    output logic                         ready_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int unsigned PTR_W = cnt_w(DEPTH);
    localparam int unsigned LVL_W = 32'($clog2(DEPTH+1));

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             ready_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // Ready comes from the registered level, so a pop never frees a slot in the same cycle.
    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
            ready_q <= (level_d < LVL_W'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_c_o = mem_q[rd_ptr_q];
    assign ready_o     = ready_q;
    assign empty_o     = empty_q;
    assign level_o     = level_q;

endmodule

// File: rtl/i2s_stream_tx.sv
// I2S transmitter: own SCLK/LRCLK divider, sample FIFO, one stereo frame per LRCLK period.
// Optional I2S_TX_HOLD_LAST_EN: on underrun repeat the last popped frame instead of silence.
module i2s_stream_tx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned SLOT_W     = DEF_SLOT_W,
    parameter int unsigned SCLK_DIV   = DEF_SCLK_DIV,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              enable_i,
    input  logic                              sample_valid_i,
    output logic                              sample_ready_o,
    input  logic [DATA_W-1:0]                 sample_l_i,
    input  logic [DATA_W-1:0]                 sample_r_i,
    output logic                              sclk_o,
    output logic                              lrclk_o,
    output logic                              i2s_dout_o,
    output logic                              underrun_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o
);

    localparam int unsigned FRAME_W = 2*SLOT_W;
    localparam int unsigned BIT_W   = cnt_w(FRAME_W);
    localparam int unsigned DIV_W   = cnt_w(SCLK_DIV);

    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    div_d;
    logic                sclk_q;
    logic                sclk_d;
    logic [BIT_W-1:0]    nxt_q;
    logic [BIT_W-1:0]    nxt_d;
    logic                lrclk_q;
    logic                lrclk_d;
    logic                dout_q;
    logic                dout_d;
    logic                underrun_q;
    logic                underrun_d;
    logic [FRAME_W-1:0]  shreg_q;
    logic [FRAME_W-1:0]  shreg_d;
`ifdef I2S_TX_HOLD_LAST_EN
    logic [FRAME_W-1:0]  last_q;
    logic [FRAME_W-1:0]  last_d;
`endif

    logic                tc;
    logic                fall;
    logic                pop;
    logic                fifo_empty;
    logic [2*DATA_W-1:0] fifo_head;
    frame_t              head_frame;

    sync_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (sample_valid_i),
        .wr_data_i   ({sample_l_i, sample_r_i}),
        .pop_i       (pop),
        .rd_data_c_o (fifo_head),
        .ready_o     (sample_ready_o),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level_o)
    );

    assign tc         = (div_q == DIV_W'(SCLK_DIV - 1));
    assign fall       = enable_i && tc && sclk_q;
    assign head_frame = pack_frame(slot_t'(fifo_head[2*DATA_W-1:DATA_W]),
                                   slot_t'(fifo_head[DATA_W-1:0]),
                                   DATA_W, SLOT_W);

    // nxt_q holds the bit index the next fall event will apply; index 0 closes one frame and loads the next.
    always_comb begin
        div_d      = div_q;
        sclk_d     = sclk_q;
        nxt_d      = nxt_q;
        lrclk_d    = lrclk_q;
        dout_d     = dout_q;
        shreg_d    = shreg_q;
        underrun_d = 1'b0;
        pop        = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
        last_d     = last_q;
`endif
        if (!enable_i) begin
            div_d   = '0;
            sclk_d  = 1'b0;
            nxt_d   = '0;
            lrclk_d = 1'b0;
            dout_d  = 1'b0;
            shreg_d = '0;
        end else begin
            if (tc) begin
                div_d  = '0;
                sclk_d = ~sclk_q;
            end else begin
                div_d  = div_q + DIV_W'(1);
            end
            if (fall) begin
                lrclk_d = (nxt_q >= BIT_W'(SLOT_W));
                dout_d  = shreg_q[FRAME_W-1];
                nxt_d   = (nxt_q == BIT_W'(FRAME_W - 1)) ? '0 : nxt_q + BIT_W'(1);
                if (nxt_q == '0) begin
                    if (fifo_empty) begin
                        underrun_d = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
                        shreg_d    = last_q;
`else
                        shreg_d    = '0;
`endif
                    end else begin
                        pop     = 1'b1;
                        shreg_d = FRAME_W'(head_frame);
`ifdef I2S_TX_HOLD_LAST_EN
                        last_d  = FRAME_W'(head_frame);
`endif
                    end
                end else begin
                    shreg_d = shreg_q << 1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q      <= '0;
            sclk_q     <= 1'b0;
            nxt_q      <= '0;
            lrclk_q    <= 1'b0;
            dout_q     <= 1'b0;
            underrun_q <= 1'b0;
            shreg_q    <= '0;
`ifdef I2S_TX_HOLD_LAST_EN
            last_q     <= '0;
`endif
        end else begin
            div_q      <= div_d;
            sclk_q     <= sclk_d;
            nxt_q      <= nxt_d;
            lrclk_q    <= lrclk_d;
            dout_q     <= dout_d;
            underrun_q <= underrun_d;
            shreg_q    <= shreg_d;
`ifdef I2S_TX_HOLD_LAST_EN
            last_q     <= last_d;
`endif
        end
    end

    assign sclk_o     = sclk_q;
    assign lrclk_o    = lrclk_q;
    assign i2s_dout_o = dout_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_stream_tx.sv
// Bench for i2s_stream_tx: two configurations driven with shared random stimulus against a frame-level model.
module tb_i2s_stream_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        valid = 1'b0;
    logic [23:0] l = '0;
    logic [23:0] r = '0;
    bit          chk_on = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit at MSB-first position p of the frame {left, pad, right, pad}.
    function automatic logic frame_bit(input logic [23:0] sl, input logic [23:0] sr,
                                       input int p, input int d, input int s);
        if (p < d)                return sl[d-1-p];
        if (p >= s && p < s + d)  return sr[d-1-(p-s)];
        return 1'b0;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int unsigned D = (g == 0) ? 24 : 16;
        localparam int unsigned S = (g == 0) ? 32 : 16;
        localparam int unsigned V = (g == 0) ? 4  : 1;
        localparam int unsigned Q = (g == 0) ? 8  : 4;

        logic                     sclk;
        logic                     lr;
        logic                     dout;
        logic                     und;
        logic                     rdy;
        logic [$clog2(Q+1)-1:0]   lvl;

        int unsigned t = 0;
        int          m_n = -1;
        int          e_lvl = 0;
        logic        e_sclk = 1'b0;
        logic        e_lr = 1'b0;
        logic        e_dout = 1'b0;
        logic        e_und = 1'b0;
        logic [23:0] ql[$];
        logic [23:0] qr[$];
        logic [23:0] cl = '0;
        logic [23:0] cr = '0;
`ifdef I2S_TX_HOLD_LAST_EN
        logic [23:0] hl = '0;
        logic [23:0] hr = '0;
`endif
        bit          acc;

        i2s_stream_tx #(
            .DATA_W     (D),
            .SLOT_W     (S),
            .SCLK_DIV   (V),
            .FIFO_DEPTH (Q)
        ) dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .enable_i       (en),
            .sample_valid_i (valid),
            .sample_ready_o (rdy),
            .sample_l_i     (l[D-1:0]),
            .sample_r_i     (r[D-1:0]),
            .sclk_o         (sclk),
            .lrclk_o        (lr),
            .i2s_dout_o     (dout),
            .underrun_o     (und),
            .fifo_level_o   (lvl)
        );

        // Model: t counts enabled clocks; fall k happens at t = 2*V*(k+1) with bit index k mod 2S.
        initial forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                t = 0; m_n = -1; e_lvl = 0;
                e_sclk = 1'b0; e_lr = 1'b0; e_dout = 1'b0; e_und = 1'b0;
                ql.delete(); qr.delete();
                cl = '0; cr = '0;
`ifdef I2S_TX_HOLD_LAST_EN
                hl = '0; hr = '0;
`endif
            end else begin
                acc   = valid && (e_lvl < int'(Q));
                e_und = 1'b0;
                if (en) begin
                    t++;
                    e_sclk = ((t / V) % 2) == 1;
                    if (t % (2*V) == 0) begin
                        m_n  = int'(((t / (2*V)) - 1) % (2*S));
                        e_lr = (m_n >= int'(S));
                        if (m_n == 0) begin
                            e_dout = frame_bit(cl, cr, int'(2*S) - 1, int'(D), int'(S));
                            if (ql.size() == 0) begin
                                e_und = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
                                cl = hl; cr = hr;
`else
                                cl = '0; cr = '0;
`endif
                            end else begin
                                cl = ql.pop_front();
                                cr = qr.pop_front();
`ifdef I2S_TX_HOLD_LAST_EN
                                hl = cl; hr = cr;
`endif
                            end
                        end else begin
                            e_dout = frame_bit(cl, cr, m_n - 1, int'(D), int'(S));
                        end
                    end
                end else begin
                    t = 0; m_n = -1;
                    e_sclk = 1'b0; e_lr = 1'b0; e_dout = 1'b0;
                    cl = '0; cr = '0;
                end
                if (acc) begin
                    ql.push_back(24'(l[D-1:0]));
                    qr.push_back(24'(r[D-1:0]));
                end
                e_lvl = ql.size();
            end
        end

        initial forever begin
            @(negedge clk);
            if (chk_on) begin
                check($sformatf("c%0d_sclk", g),  32'(sclk), 32'(e_sclk));
                check($sformatf("c%0d_lrclk", g), 32'(lr),   32'(e_lr));
                check($sformatf("c%0d_dout", g),  32'(dout), 32'(e_dout));
                check($sformatf("c%0d_under", g), 32'(und),  32'(e_und));
                check($sformatf("c%0d_level", g), 32'(lvl),  32'(e_lvl));
                check($sformatf("c%0d_ready", g), 32'(rdy),  32'(e_lvl < int'(Q)));
            end
        end
    end

    task automatic random_phase(input int cycles, input int unsigned vprob);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            valid = ($urandom_range(vprob - 1, 0) == 0);
            l     = 24'($urandom);
            r     = 24'($urandom);
            if ($urandom_range(1499, 0) == 0) en = ~en;
        end
    endtask

    initial begin
        bit found;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Directed frame: F00000 / 0ABCDE then run on into underrun.
        @(negedge clk);
        valid = 1'b1; l = 24'hF00000; r = 24'h0ABCDE;
        @(negedge clk);
        valid = 1'b0; en = 1'b1;
        repeat (1100) @(negedge clk);

        // Fill the FIFO with the serial side idle.
        en = 1'b0; valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            l = 24'($urandom); r = 24'($urandom);
            @(negedge clk);
        end
        valid = 1'b0;

        // Producer holding valid while running: full FIFO refills after each pop.
        en = 1'b1; valid = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            l = 24'($urandom); r = 24'($urandom);
        end
        valid = 1'b0;

        random_phase(2500, 4);
        random_phase(2500, 64);
        random_phase(2500, 512);
        random_phase(1500, 2048);

        // Reset in the middle of a frame at bit index 20.
        en = 1'b1; valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (g_cfg[0].m_n == 20) found = 1'b1;
        end
        check("reach_n20", 32'(found), 32'(1));
        #1 rst = 1'b1;
        #1;
        check("rst_sclk",  32'(g_cfg[0].sclk), 32'(0));
        check("rst_lrclk", 32'(g_cfg[0].lr),   32'(0));
        check("rst_dout",  32'(g_cfg[0].dout), 32'(0));
        check("rst_under", 32'(g_cfg[0].und),  32'(0));
        check("rst_level", 32'(g_cfg[0].lvl),  32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        valid = 1'b1; l = 24'($urandom); r = 24'($urandom);
        @(negedge clk);
        l = 24'($urandom); r = 24'($urandom);
        @(negedge clk);
        valid = 1'b0;
        repeat (1300) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
